c2f_chunk_buffer: RTL
=====================

Name: c2f_chunk_buffer

Overview:
- CPU-to-FPGA chunk ring buffer that sits directly upstream of the example consumer.
- Accepts a stream of 64-bit QWs from the TLP receive path and packs them into fixed-size chunks in an internal RAM.
- Publishes a chunk write pointer (wrPtr) and read pointer (rdPtr); the consumer reads any QW of the oldest chunk by offset.
- The consumer's dtAck pulse retires the oldest chunk and advances rdPtr.

Parameters:
- NUMCHUNKS_NBITS, 2, log2 of the number of chunk slots; usable capacity is 2^NUMCHUNKS_NBITS-1 chunks.
- CHUNKSIZE_NBITS, 7, log2 of chunk size in bytes. QWs per chunk = 2^(CHUNKSIZE_NBITS-3). Legal values are >=3; the value 3 means one QW per chunk.

Ports:
- sysClk_in  in  1  system clock
- sysReset_in  in  1  asynchronous, active-high reset
- wrData_in  in  64  QW from the TLP receive path
- wrValid_in  in  1  wrData_in is valid
- wrReady_out  out  1  buffer accepts wrData_in this cycle
- wrPtr_out  out  NUMCHUNKS_NBITS  next slot to fill; consumer's wrPtr_in
- rdPtr_out  out  NUMCHUNKS_NBITS  oldest unretired slot; consumer's rdPtr_in
- rdOffset_in  in  CHUNKSIZE_NBITS-3  QW offset within slot rdPtr
- rdData_out  out  64  RAM[rdPtr][rdOffset], one-cycle latency
- dtAck_in  in  1  one-cycle pulse: consumer has finished slot rdPtr
- commitCount_out  out  32  chunks committed since reset (feature-gated)
- ackErr_out  out  1  sticky: dtAck received while empty (feature-gated)

Behaviour:
- Reset (async assert, sync release): wrPtr=0, rdPtr=0, wrOffset=0, rdData_out=0, state=S_WAIT, wrReady_out=0, commitCount_out=0, ackErr_out=0. RAM contents are not reset.
- empty = (wrPtr==rdPtr). full = (wrPtr+1 mod 2^NUMCHUNKS_NBITS == rdPtr).
- Write FSM:
  - S_WAIT: wrReady_out=0. If !full, go to S_FILL next cycle.
  - S_FILL: wrReady_out=1. A beat is accepted when wrValid_in && wrReady_out. Each accepted beat writes RAM[wrPtr][wrOffset] and increments wrOffset (mod chunk QWs).
  - On the beat where wrOffset is all-ones: wrOffset returns to 0, wrPtr increments (wraps) at that clock edge, and the FSM goes to S_WAIT.
  - One-QW chunks (CHUNKSIZE_NBITS=3): every accepted beat commits.
  - Minimum one-cycle bubble between chunks (the S_WAIT cycle re-evaluates full with the updated wrPtr).
- wrPtr never becomes visible before the last QW of its chunk is in RAM. The RAM write and the wrPtr increment happen on the same edge. The RAM read must return the new data on the following cycle (no read-during-write hazard across slots).
- Read path:
  - rdData_out registers RAM[rdPtr][rdOffset_in] every cycle, unconditionally.
  - Address presented in cycle N → data valid in cycle N+1, matching the consumer's S_IDLE→S_READ0 timing.
- dtAck_in:
  - When !empty, rdPtr increments (wraps) at the next edge.
  - When empty, the ack is ignored and rdPtr is unchanged; with the feature enabled, ackErr_out is set.
- Simultaneous commit and dtAck: both pointers update independently on the same edge. The full/empty evaluation on the next cycle uses both new values.
- Wrap-around: pointers roll from 2^NUMCHUNKS_NBITS-1 to 0 with no special casing.
- Reset mid-chunk: the partial chunk is discarded (wrOffset=0, wrPtr unchanged at 0).

Optional Feature:
- Macro C2F_CHUNK_BUFFER_STATS_EN.
- Defined:
  - commitCount_out increments by 1 per committed chunk and wraps at 2^32.
  - ackErr_out is sticky-set by dtAck_in while empty and is cleared only by reset.
- Undefined: both ports remain present and are tied to 0; no counter logic is inferred.

Decomposition:
- tlp_xcvr_pkg: C2FChunkPtr (NUMCHUNKS_NBITS), C2FChunkOffset (CHUNKSIZE_NBITS-3), C2F_CHUNKSIZE_NBITS and C2F_NUMCHUNKS_NBITS constants, uint64 and uint32 types, and the write-FSM State enum.
- One sub-module, c2f_chunk_ram: simple dual-port RAM.
  - Depth 2^(NUMCHUNKS_NBITS+CHUNKSIZE_NBITS-3), width 64.
  - Registered read port, write address {wrPtr,wrOffset}, read address {rdPtr,rdOffset}.
  - Infers block RAM.

Test Plan:
(Defaults: 4 slots, 16 QWs per chunk.)
- Reset, then wrValid held low → wrReady_out=1 from the 2nd cycle after release; wrPtr_out=0, rdPtr_out=0, rdData_out=0.
- Push 16 QWs 0x100..0x10F → wrPtr_out=1 the cycle after the 16th beat; rdOffset_in=5 gives rdData_out=0x105 one cycle later.
- Push 3 full chunks with no acks → after the 3rd commit wrReady_out stays 0 (full). One dtAck_in pulse → rdPtr_out=1, and wrReady_out=1 two cycles later.
- Commit the 4th chunk on the same edge as a dtAck → wrPtr and rdPtr both advance. Run 10 chunks through with acks → pointers wrap 3→0 and data is intact.
- dtAck_in pulse while empty → rdPtr_out unchanged. With C2F_CHUNK_BUFFER_STATS_EN, ackErr_out=1 and stays 1; without it, ackErr_out=0.
- Assert sysReset_in after 7 QWs of a chunk → wrPtr_out=0 immediately (async). A following full chunk lands in slot 0 with offsets 0..15 correct.

Source files
------------

// File: rtl/c2f_chunk_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlp_xcvr_pkg
// Description : Shared types and constants for the CPU-to-FPGA chunk buffer:
//               chunk pointer/offset types, QW/DW types and write-FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package tlp_xcvr_pkg;

    // Offset field width; a one-QW chunk still gets a 1-bit (unused) field
    function automatic int offsetNbits(input int chunkSizeNbits);
        return (chunkSizeNbits > 3) ? chunkSizeNbits - 3 : 1;
    endfunction

    localparam int C2F_NUMCHUNKS_NBITS = 2;
    localparam int C2F_CHUNKSIZE_NBITS = 7;

    typedef logic [63:0] uint64;
    typedef logic [31:0] uint32;

    typedef logic [C2F_NUMCHUNKS_NBITS-1:0]               C2FChunkPtr;
    typedef logic [offsetNbits(C2F_CHUNKSIZE_NBITS)-1:0]  C2FChunkOffset;

    // Write-side FSM: wait for a free slot, then fill it
    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_FILL = 1'b1
    } State;

endpackage
`default_nettype wire

// File: rtl/c2f_chunk_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : c2f_chunk_ram
// Description : Simple dual-port chunk RAM, one write port and one registered
//               read port. Read-first behaviour; the read register is reset
//               so the consumer sees zero data out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module c2f_chunk_ram #(
    parameter int ADDR_NBITS = 6,
    parameter int DATA_NBITS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wrEn,
    input  logic [ADDR_NBITS-1:0] i_wrAddr,
    input  logic [DATA_NBITS-1:0] i_wrData,
    input  logic [ADDR_NBITS-1:0] i_rdAddr,
    output logic [DATA_NBITS-1:0] o_rdData
);
    localparam int c_depth = 1 << ADDR_NBITS;

    logic [DATA_NBITS-1:0] r_mem [0:c_depth-1];
    logic [DATA_NBITS-1:0] r_rdData;

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Registered read every cycle, one-cycle address-to-data latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule
`default_nettype wire

// File: rtl/c2f_chunk_buffer.sv
`default_nettype none
// ============================================================================
// Module      : c2f_chunk_buffer
// Description : CPU-to-FPGA chunk ring buffer. Packs incoming QWs into fixed
//               size chunk slots, publishes write/read chunk pointers and lets
//               the consumer read the oldest chunk by QW offset. dtAck_in
//               retires the oldest chunk.
//               Optional statistics (commit counter, sticky ack error) are
//               built when C2F_CHUNK_BUFFER_STATS_EN is defined; otherwise the
//               outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module c2f_chunk_buffer
    import tlp_xcvr_pkg::*;
#(
    parameter int NUMCHUNKS_NBITS = C2F_NUMCHUNKS_NBITS,
    parameter int CHUNKSIZE_NBITS = C2F_CHUNKSIZE_NBITS
) (
    input  logic                                     sysClk_in,
    input  logic                                     sysReset_in,
    input  logic [63:0]                              wrData_in,
    input  logic                                     wrValid_in,
    output logic                                     wrReady_out,
    output logic [NUMCHUNKS_NBITS-1:0]               wrPtr_out,
    output logic [NUMCHUNKS_NBITS-1:0]               rdPtr_out,
    input  logic [offsetNbits(CHUNKSIZE_NBITS)-1:0]  rdOffset_in,
    output logic [63:0]                              rdData_out,
    input  logic                                     dtAck_in,
    output logic [31:0]                              commitCount_out,
    output logic                                     ackErr_out
);
    localparam int c_offNbits  = offsetNbits(CHUNKSIZE_NBITS);
    localparam int c_addrNbits = NUMCHUNKS_NBITS + CHUNKSIZE_NBITS - 3;
    localparam logic [NUMCHUNKS_NBITS-1:0] c_ptrOne = NUMCHUNKS_NBITS'(1);
    localparam logic [c_offNbits-1:0]      c_offOne = c_offNbits'(1);

    State                       r_state;
    State                       w_nextState;
    logic [NUMCHUNKS_NBITS-1:0] r_wrPtr;
    logic [NUMCHUNKS_NBITS-1:0] r_rdPtr;
    logic [NUMCHUNKS_NBITS-1:0] w_wrPtrInc;
    logic [NUMCHUNKS_NBITS-1:0] w_rdPtrInc;
    logic [c_offNbits-1:0]      r_wrOffset;
    logic [c_addrNbits-1:0]     w_wrAddr;
    logic [c_addrNbits-1:0]     w_rdAddr;
    logic                       w_empty;
    logic                       w_full;
    logic                       w_accept;
    logic                       w_offsetLast;
    logic                       w_commit;
    logic                       w_retire;
    logic                       w_wrReady;

    assign w_wrPtrInc = r_wrPtr + c_ptrOne;
    assign w_rdPtrInc = r_rdPtr + c_ptrOne;
    assign w_empty    = (r_wrPtr == r_rdPtr);
    assign w_full     = (w_wrPtrInc == r_rdPtr);

    // Acceptance is decoded from the state directly so it never loops
    // through the next-state logic.
    assign w_accept   = wrValid_in && (r_state == S_FILL);
    assign w_commit   = w_accept && w_offsetLast;
    assign w_retire   = dtAck_in && !w_empty;

    generate
        if (CHUNKSIZE_NBITS > 3) begin : g_multiQw
            assign w_offsetLast = (r_wrOffset == {c_offNbits{1'b1}});
            assign w_wrAddr     = {r_wrPtr, r_wrOffset};
            assign w_rdAddr     = {r_rdPtr, rdOffset_in};
        end else begin : g_singleQw
            // One QW per chunk: every accepted beat closes its chunk
            assign w_offsetLast = 1'b1;
            assign w_wrAddr     = r_wrPtr;
            assign w_rdAddr     = r_rdPtr;
        end
    endgenerate

    // Write FSM state register
    always_ff @(posedge sysClk_in or posedge sysReset_in) begin
        if (sysReset_in) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Write FSM next state; S_WAIT gives the one-cycle bubble in which full
    // is re-evaluated against the freshly advanced wrPtr.
    always_comb begin
        w_nextState = r_state;
        w_wrReady   = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (!w_full) begin
                    w_nextState = S_FILL;
                end
            end
            S_FILL: begin
                w_wrReady = 1'b1;
                if (w_commit) begin
                    w_nextState = S_WAIT;
                end
            end
            default: begin
                w_nextState = S_WAIT;
            end
        endcase
    end

    // Pointers and fill offset; the last QW write and the wrPtr bump share
    // one edge so a published slot is always complete.
    always_ff @(posedge sysClk_in or posedge sysReset_in) begin
        if (sysReset_in) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_wrOffset <= '0;
        end else begin
            if (w_accept) begin
                r_wrOffset <= w_offsetLast ? '0 : (r_wrOffset + c_offOne);
            end
            if (w_commit) begin
                r_wrPtr <= w_wrPtrInc;
            end
            if (w_retire) begin
                r_rdPtr <= w_rdPtrInc;
            end
        end
    end

    c2f_chunk_ram #(
        .ADDR_NBITS (c_addrNbits),
        .DATA_NBITS (64)
    ) u_chunkRam (
        .clk      (sysClk_in),
        .rst      (sysReset_in),
        .i_wrEn   (w_accept),
        .i_wrAddr (w_wrAddr),
        .i_wrData (wrData_in),
        .i_rdAddr (w_rdAddr),
        .o_rdData (rdData_out)
    );

    assign wrReady_out = w_wrReady;
    assign wrPtr_out   = r_wrPtr;
    assign rdPtr_out   = r_rdPtr;

`ifdef C2F_CHUNK_BUFFER_STATS_EN
    logic [31:0] r_commitCount;
    logic        r_ackErr;

    // Commit counter (free-running wrap) and sticky ack-while-empty flag
    always_ff @(posedge sysClk_in or posedge sysReset_in) begin
        if (sysReset_in) begin
            r_commitCount <= '0;
            r_ackErr      <= 1'b0;
        end else begin
            if (w_commit) begin
                r_commitCount <= r_commitCount + 32'd1;
            end
            if (dtAck_in && w_empty) begin
                r_ackErr <= 1'b1;
            end
        end
    end

    assign commitCount_out = r_commitCount;
    assign ackErr_out      = r_ackErr;
`else
    assign commitCount_out = '0;
    assign ackErr_out      = 1'b0;
`endif

endmodule
`default_nettype wire
